master_port: RTL and testbench

- Initiator end of the team's serial system bus; the counterpart of the slave-side serial port.
- Accepts one parallel read or write request from a local device, such as a CPU stub or demo controller.
- For a write, serializes address then data onto the bus; for a read, serializes the address, then deserializes the read data returned by the slave.
- Sits between the local device and the bus interconnect/arbiter. One outstanding transaction at a time.

---
 rtl/bus_pkg.sv | 8 +
 rtl/serial_rx_shifter.sv | 36 +++
 rtl/master_port.sv | 153 +++++++++++++++
 tb/tb_master_port.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared serial system bus definitions (state encoding, mode values, default widths) for master and slave ports.
package bus_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_RDY, ADDR, WDATA, RWAIT, DONE} state_e;
    localparam logic MODE_READ      = 1'b0;
    localparam logic MODE_WRITE     = 1'b1;
    localparam int   BUS_ADDR_WIDTH = 12;
    localparam int   BUS_DATA_WIDTH = 8;
endpackage

// File: rtl/serial_rx_shifter.sv
// serial_rx_shifter: LSB-first deserializer of DATA_WIDTH bits with bit enable, clear and done flag.
//   clk, rstn : clock, synchronous active-low reset
//   clr_i     : restart (index and word cleared), has priority over en_i
//   en_i      : bit_i is valid this cycle and is stored at the current index
//   data_o    : assembled word including the bit accepted this cycle
//   done_o    : the bit accepted this cycle completes the word
module serial_rx_shifter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic                  bit_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  done_o
);
    localparam int IW = $clog2(DATA_WIDTH) + 1;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    always_comb begin
        idx_d  = en_i ? idx_q + IW'(1) : idx_q;
        data_d = en_i ? (data_q & ~(DATA_WIDTH'(1) << idx_q)) | (DATA_WIDTH'(bit_i) << idx_q) : data_q;
    end
    always_ff @(posedge clk) begin
        if (!rstn || clr_i) begin
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            idx_q  <= idx_d;
            data_q <= data_d;
        end
    end
    assign data_o = data_d;
    assign done_o = en_i && (idx_q == IW'(DATA_WIDTH - 1));
endmodule

// File: rtl/master_port.sv
// master_port: initiator of the serial system bus; serializes one local read/write request at a time.
//   clk, rstn            : clock, synchronous active-low reset
//   dreq_i/dmode_i       : request strobe (taken only while dready_o) and mode (0 read, 1 write)
//   daddr_i/dwdata_i     : request address and write data
//   dready_o             : idle, request can be accepted
//   dvalid_o/derr_o      : one-cycle completion pulse, error flag on timeout
//   drdata_o             : last successfully read word, held until the next successful read
//   mwdata_o/mvalid_o    : serial address/write data bit and its valid
//   mmode_o              : mode of the transaction in flight, 0 when idle
//   srdata_i/svalid_i    : serial read data bit from the slave and its valid
//   sready_i             : slave ready to start a transaction
module master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dreq_i,
    input  logic                  dmode_i,
    input  logic [ADDR_WIDTH-1:0] daddr_i,
    input  logic [DATA_WIDTH-1:0] dwdata_i,
    output logic                  dready_o,
    output logic                  dvalid_o,
    output logic [DATA_WIDTH-1:0] drdata_o,
    output logic                  derr_o,
    output logic                  mwdata_o,
    output logic                  mmode_o,
    output logic                  mvalid_o,
    input  logic                  srdata_i,
    input  logic                  svalid_i,
    input  logic                  sready_i
);
    localparam int BW = $clog2((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH) + 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [BW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         tmo_q, tmo_d, tmo_inc;
    logic                  rx_en, rx_clr, rx_done;
    logic [DATA_WIDTH-1:0] rx_word;
    // Stray svalid outside RWAIT never reaches the shifter; leaving RWAIT clears it.
    assign rx_en    = (state_q == RWAIT) && svalid_i;
    assign rx_clr   = state_q != RWAIT;
    assign tmo_inc  = (&tmo_q) ? tmo_q : tmo_q + TW'(1);
    assign drdata_o = rdata_q;
    serial_rx_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_rx (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (rx_clr),
        .en_i   (rx_en),
        .bit_i  (srdata_i),
        .data_o (rx_word),
        .done_o (rx_done)
    );
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            mode_q  <= MODE_READ;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end
    // The bit and timeout counters fall back to zero in every state that does not advance them,
    // so each state is entered with fresh counts.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = '0;
        tmo_d    = '0;
        dready_o = 1'b0;
        dvalid_o = 1'b0;
        derr_o   = 1'b0;
        mwdata_o = 1'b0;
        mvalid_o = 1'b0;
        mmode_o  = (state_q != IDLE) && mode_q;
        case (state_q)
            IDLE: begin
                dready_o = 1'b1;
                if (dreq_i) begin
                    mode_d  = dmode_i;
                    addr_d  = daddr_i;
                    wdata_d = dwdata_i;
                    err_d   = 1'b0;
                    state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (sready_i) state_d = ADDR;
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else tmo_d = tmo_inc;
            end
            ADDR: begin
                mvalid_o = 1'b1;
                mwdata_o = |(addr_q & (ADDR_WIDTH'(1) << cnt_q));
                cnt_d    = cnt_q + BW'(1);
                if (cnt_q == BW'(ADDR_WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = (mode_q == MODE_WRITE) ? WDATA : RWAIT;
                end
            end
            WDATA: begin
                mvalid_o = 1'b1;
                mwdata_o = |(wdata_q & (DATA_WIDTH'(1) << cnt_q));
                cnt_d    = cnt_q + BW'(1);
                if (cnt_q == BW'(DATA_WIDTH - 1)) state_d = DONE;
            end
            RWAIT: begin
                // drdata is loaded on the final bit so it is valid together with dvalid.
                if (rx_done) begin
                    rdata_d = rx_word;
                    state_d = DONE;
                end else if (!svalid_i) begin
                    if (tmo_q == TW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else tmo_d = tmo_inc;
                end
            end
            DONE: begin
                dvalid_o = 1'b1;
                derr_o   = err_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_master_port.sv
// tb_master_port: directed bench for master_port with a transaction-level reference model.
module tb_master_port;
    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0, rstn = 1'b0;
    logic          dreq = 1'b0, dmode = 1'b0, srdata = 1'b0, svalid = 1'b0, sready = 1'b0;
    logic [AW-1:0] daddr = '0;
    logic [DW-1:0] dwdata = '0;
    logic          dready, dvalid, derr, mwdata, mmode, mvalid;
    logic [DW-1:0] drdata;

    int tests = 0, fails = 0, cyc = 0;

    master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .dreq_i   (dreq),
        .dmode_i  (dmode),
        .daddr_i  (daddr),
        .dwdata_i (dwdata),
        .dready_o (dready),
        .dvalid_o (dvalid),
        .drdata_o (drdata),
        .derr_o   (derr),
        .mwdata_o (mwdata),
        .mmode_o  (mmode),
        .mvalid_o (mvalid),
        .srdata_i (srdata),
        .svalid_i (svalid),
        .sready_i (sready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a request becomes a queue of serial bits (address then write data, LSB first);
    // it waits for sready, drains the queue one bit per cycle, then for reads collects DW bits.
    bit     started = 0;
    bit     m_idle = 1, m_done = 0, m_err = 0, m_granted = 0, m_listen = 0, m_mode = 0;
    bit     m_txq[$];
    int     m_wait = 0, m_rxcnt = 0;
    logic [DW-1:0] m_rxval = '0, m_rdata = '0;

    always @(negedge clk) begin
        if (started) begin
            check("dready", dready, m_idle);
            check("dvalid", dvalid, m_done);
            check("derr", derr, m_done && m_err);
            check("mvalid", mvalid, !m_idle && !m_done && m_granted && m_txq.size() > 0);
            check("mwdata", mwdata, (!m_idle && !m_done && m_granted && m_txq.size() > 0) ? m_txq[0] : 1'b0);
            check("mmode", mmode, !m_idle && m_mode);
            check("drdata", drdata, m_rdata);
        end
        if (!rstn) begin
            started = 1; m_idle = 1; m_done = 0; m_err = 0; m_granted = 0; m_listen = 0;
            m_mode = 0; m_rdata = '0; m_txq.delete();
        end else if (m_done) begin
            m_done = 0; m_idle = 1;
        end else if (m_idle) begin
            if (dreq) begin
                m_idle = 0; m_mode = dmode; m_granted = 0; m_wait = 0; m_txq.delete();
                for (int i = 0; i < AW; i++) m_txq.push_back(daddr[i]);
                if (dmode) for (int i = 0; i < DW; i++) m_txq.push_back(dwdata[i]);
            end
        end else if (!m_granted) begin
            if (sready) m_granted = 1;
            else begin
                m_wait++;
                if (m_wait == TMO) begin m_done = 1; m_err = 1; end
            end
        end else if (m_txq.size() > 0) begin
            void'(m_txq.pop_front());
            if (m_txq.size() == 0) begin
                if (m_mode) begin m_done = 1; m_err = 0; end
                else begin m_listen = 1; m_wait = 0; m_rxcnt = 0; end
            end
        end else if (m_listen) begin
            if (svalid) begin
                m_rxval[m_rxcnt] = srdata;
                m_rxcnt++;
                m_wait = 0;
                if (m_rxcnt == DW) begin m_done = 1; m_err = 0; m_rdata = m_rxval; m_listen = 0; end
            end else begin
                m_wait++;
                if (m_wait == TMO) begin m_done = 1; m_err = 1; m_listen = 0; end
            end
        end
    end

    // Transaction monitor feeding the hand-computed checks.
    bit         cap[$];
    int         first_mv = -1, last_mv = -1, dv_n = 0, dv_cyc = -1, t_req = 0;
    logic       dv_err = 1'b0;
    logic [DW-1:0] dv_rd = '0;

    always @(negedge clk) begin
        if (mvalid) begin
            cap.push_back(mwdata);
            if (first_mv < 0) first_mv = cyc;
            last_mv = cyc;
        end
        if (dvalid) begin
            dv_n++; dv_cyc = cyc; dv_err = derr; dv_rd = drdata;
        end
    end

    function automatic logic [31:0] cap_val();
        logic [31:0] v = '0;
        for (int i = 0; i < cap.size() && i < 32; i++) v[i] = cap[i];
        return v;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        cap.delete(); first_mv = -1; last_mv = -1; dv_n = 0; dv_cyc = -1;
    endtask

    task automatic request(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dreq = 1'b1; dmode = m; daddr = a; dwdata = d; t_req = cyc;
        tick();
        dreq = 1'b0;
    endtask

    task automatic wait_dv(input string name, input int budget);
        for (int i = 0; i < budget && dv_n == 0; i++) tick();
        check({name, "_completed"}, dv_n, 1);
    endtask

    initial begin
        logic [DW-1:0] rbyte;
        rbyte = 8'h3C;
        tick(3);
        rstn = 1'b1;
        check("rst_dready", dready, 1'b1);
        check("rst_mvalid", mvalid, 1'b0);
        check("rst_drdata", drdata, 8'h00);

        // Write 0xA5 to 0x3C1
        clear_mon(); sready = 1'b1;
        request(1'b1, 12'h3C1, 8'hA5);
        wait_dv("wr", 40);
        check("wr_nbits", cap.size(), 20);
        check("wr_bits", cap_val(), 32'h000A53C1);
        check("wr_first_mv", first_mv, t_req + 2);
        check("wr_last_mv", last_mv, t_req + 21);
        check("wr_dv_cyc", dv_cyc, t_req + 22);
        check("wr_derr", dv_err, 1'b0);
        check("wr_dready_after", dready, 1'b1);

        // Read 0x005 returning 0x3C with a gap; stray svalid and extra dreq during ADDR
        clear_mon();
        request(1'b0, 12'h005, 8'hFF);
        tick();
        svalid = 1'b1; srdata = 1'b1; dreq = 1'b1; dmode = 1'b1; daddr = 12'hFFF;
        tick(2);
        svalid = 1'b0; srdata = 1'b0; dreq = 1'b0;
        while (cyc < t_req + 14) tick();
        for (int i = 0; i < 4; i++) begin svalid = 1'b1; srdata = rbyte[i]; tick(); end
        svalid = 1'b0; srdata = 1'b0;
        tick(2);
        for (int i = 4; i < 8; i++) begin svalid = 1'b1; srdata = rbyte[i]; tick(); end
        svalid = 1'b0; srdata = 1'b0;
        wait_dv("rd", 40);
        check("rd_nbits", cap.size(), 12);
        check("rd_addr_bits", cap_val(), 32'h005);
        check("rd_data", dv_rd, 8'h3C);
        check("rd_dv_cyc", dv_cyc, t_req + 24);
        check("rd_derr", dv_err, 1'b0);

        // sready held low for 10 wait cycles
        clear_mon(); sready = 1'b0;
        request(1'b1, 12'h0F0, 8'h5A);
        tick(10);
        sready = 1'b1;
        wait_dv("late_rdy", 60);
        check("late_first_mv", first_mv, t_req + 12);
        check("late_bits", cap_val(), 32'h0005A0F0);
        check("late_dv_cyc", dv_cyc, t_req + 32);
        check("late_derr", dv_err, 1'b0);

        // sready never rises: timeout in the wait
        clear_mon(); sready = 1'b0;
        request(1'b1, 12'h7FF, 8'hFF);
        wait_dv("rdy_tmo", 40);
        check("rdy_tmo_cyc", dv_cyc, t_req + 17);
        check("rdy_tmo_derr", dv_err, 1'b1);
        check("rdy_tmo_nbits", cap.size(), 0);
        check("rdy_tmo_drdata", dv_rd, 8'h3C);

        // Read with no svalid: timeout after the address
        clear_mon(); sready = 1'b1;
        request(1'b0, 12'hABC, 8'h00);
        wait_dv("rd_tmo", 60);
        check("rd_tmo_cyc", dv_cyc, t_req + 30);
        check("rd_tmo_derr", dv_err, 1'b1);
        check("rd_tmo_drdata", dv_rd, 8'h3C);

        // Reset during WDATA bit 3
        clear_mon();
        request(1'b1, 12'h123, 8'h77);
        while (cyc < t_req + 17) tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("rst_mid_mvalid", mvalid, 1'b0);
        check("rst_mid_dready", dready, 1'b1);
        tick(5);
        check("rst_mid_no_dv", dv_n, 0);
        clear_mon();
        request(1'b1, 12'h001, 8'h11);
        wait_dv("post_rst", 40);
        check("post_rst_bits", cap_val(), 32'h00011001);
        check("post_rst_dv_cyc", dv_cyc, t_req + 22);
        check("post_rst_derr", dv_err, 1'b0);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
